// File: rtl/pll_lock_sequencer.sv
// Supervises the iCE40 PLL from the reference clock: pulses RESETB, waits for a
// stable synchronized lock, then releases the design reset; retries on timeout.
module pll_lock_sequencer #(
  parameter int unsigned PLL_RESET_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       design_reset,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_count
);

  localparam int unsigned MAX_AB     = (PLL_RESET_CYCLES > LOCK_STABLE_CYCLES) ?
                                       PLL_RESET_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                                       MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES) + 1;
  localparam int unsigned RW         = 4;

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lock_meta;
  logic          lock_s;

  // Output encoding per state: {pll_resetb, design_reset, ready, fail}
  function automatic logic [3:0] out_bits(input state_t s);
    return {s != ST_PLL_RST, s != ST_RUN, s == ST_RUN, s == ST_FAIL};
  endfunction

  // Two-flop synchronizer for the asynchronous PLL lock output
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= locked;
      lock_s    <= lock_meta;
    end
  end

  // Sequencer: outputs are loaded together with the state they belong to
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                                      <= ST_PLL_RST;
      cnt                                        <= '0;
      retry_count                                <= '0;
      {pll_resetb, design_reset, ready, fail}    <= out_bits(ST_PLL_RST);
    end else if (restart) begin
      state                                      <= ST_PLL_RST;
      cnt                                        <= '0;
      retry_count                                <= '0;
      {pll_resetb, design_reset, ready, fail}    <= out_bits(ST_PLL_RST);
    end else begin
      case (state)
        ST_PLL_RST: begin
          if (cnt == CW'(PLL_RESET_CYCLES - 1)) begin
            state                                   <= ST_WAIT_LOCK;
            cnt                                     <= '0;
            {pll_resetb, design_reset, ready, fail} <= out_bits(ST_WAIT_LOCK);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state                                   <= ST_STABLE;
            cnt                                     <= '0;
            {pll_resetb, design_reset, ready, fail} <= out_bits(ST_STABLE);
          end else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            cnt <= '0;
            if (retry_count == RW'(MAX_RETRIES)) begin
              state                                   <= ST_FAIL;
              {pll_resetb, design_reset, ready, fail} <= out_bits(ST_FAIL);
            end else begin
              state                                   <= ST_PLL_RST;
              retry_count                             <= retry_count + RW'(1);
              {pll_resetb, design_reset, ready, fail} <= out_bits(ST_PLL_RST);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_STABLE: begin
          // Lock loss takes precedence over a completing stability count
          if (!lock_s) begin
            state                                   <= ST_WAIT_LOCK;
            cnt                                     <= '0;
            {pll_resetb, design_reset, ready, fail} <= out_bits(ST_WAIT_LOCK);
          end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
            state                                   <= ST_RUN;
            cnt                                     <= '0;
            retry_count                             <= '0;
            {pll_resetb, design_reset, ready, fail} <= out_bits(ST_RUN);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RUN: begin
          // No PLL reset here: the iCE40 PLL relocks by itself
          if (!lock_s) begin
            state                                   <= ST_WAIT_LOCK;
            cnt                                     <= '0;
            {pll_resetb, design_reset, ready, fail} <= out_bits(ST_WAIT_LOCK);
          end
        end
        ST_FAIL: begin
          cnt <= '0;
        end
        default: begin
          state                                   <= ST_PLL_RST;
          cnt                                     <= '0;
          retry_count                             <= '0;
          {pll_resetb, design_reset, ready, fail} <= out_bits(ST_PLL_RST);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: per-edge vector table plus hand-written
// timeout/fail, recovery and asynchronous-reset sequences.
module tb_pll_lock_sequencer;

  // Expected output vector: {pll_resetb, design_reset, ready, fail, retry_count[3:0]}
  localparam logic [7:0] E_RST  = 8'b0100_0000;
  localparam logic [7:0] E_WAIT = 8'b1100_0000;
  localparam logic [7:0] E_RUN  = 8'b1010_0000;

  typedef struct {
    logic       locked;
    logic       restart;
    logic [7:0] exp;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       locked;
  logic       restart;
  logic       pll_resetb;
  logic       design_reset;
  logic       ready;
  logic       fail;
  logic [3:0] retry_count;

  int tests  = 0;
  int failed = 0;
  vec_t vecs[$];

  pll_lock_sequencer #(
    .PLL_RESET_CYCLES   (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES        (2)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .locked      (locked),
    .restart     (restart),
    .pll_resetb  (pll_resetb),
    .design_reset(design_reset),
    .ready       (ready),
    .fail        (fail),
    .retry_count (retry_count)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] outv();
    return {pll_resetb, design_reset, ready, fail, retry_count};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: {pll_resetb,design_reset,ready,fail,retry_count} got %b required %b",
               name, act, exp);
    end
  endtask

  // One active edge, then park on the falling edge for sampling/driving
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic add(input logic l, input logic r, input logic [7:0] e, input int n);
    vec_t v;
    v.locked  = l;
    v.restart = r;
    v.exp     = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  function automatic logic [7:0] timeout_model(input int off);
    logic [3:0] r;
    int base;
    if (off >= 108) return {4'b1101, 4'd2};
    r    = (off < 36) ? 4'd0 : (off < 72) ? 4'd1 : 4'd2;
    base = 36 * int'(r);
    if (off - base < 4) return {4'b0100, r};
    return {4'b1100, r};
  endfunction

  // Bring-up from reset release with locked already high
  task automatic bringup_walk(input string tag);
    for (int e = 1; e <= 14; e++) begin
      tick();
      check($sformatf("%s_edge%0d", tag, e), outv(),
            (e < 4) ? E_RST : (e < 13) ? E_WAIT : E_RUN);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    locked  = 1'b0;
    restart = 1'b0;

    // Edge numbering: vecs[i] covers edge i+1 after reset release
    add(0, 0, E_RST,  3);
    add(0, 0, E_WAIT, 10);
    add(1, 0, E_WAIT, 10);
    add(1, 0, E_RUN,  3);
    add(0, 0, E_RUN,  2);
    add(0, 0, E_WAIT, 1);
    add(1, 0, E_WAIT, 10);
    add(1, 0, E_RUN,  2);
    add(0, 1, E_RST,  1);
    add(0, 0, E_RST,  3);
    add(0, 0, E_WAIT, 2);
    add(1, 0, E_WAIT, 5);
    add(0, 0, E_WAIT, 1);
    add(1, 0, E_WAIT, 10);
    add(1, 0, E_RUN,  2);

    tick();
    tick();
    check("reset_values", outv(), E_RST);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      locked  = vecs[i].locked;
      restart = vecs[i].restart;
      tick();
      check($sformatf("vec_edge%0d", i + 1), outv(), vecs[i].exp);
    end

    // Lock stuck low: two retries, then FAIL
    locked  = 1'b0;
    restart = 1'b1;
    for (int off = 0; off <= 112; off++) begin
      tick();
      restart = 1'b0;
      check($sformatf("timeout_off%0d", off), outv(), timeout_model(off));
    end

    // Recovery from FAIL via restart
    locked  = 1'b1;
    restart = 1'b1;
    for (int off = 0; off <= 14; off++) begin
      tick();
      restart = 1'b0;
      check($sformatf("recover_off%0d", off), outv(),
            (off < 4) ? E_RST : (off < 13) ? E_WAIT : E_RUN);
    end

    // Asynchronous reset in RUN, between edges
    #2 reset_n = 1'b0;
    #1 check("async_reset_run", outv(), E_RST);
    tick();
    check("reset_held", outv(), E_RST);
    reset_n = 1'b1;
    bringup_walk("after_run_reset");

    // Asynchronous reset in STABLE, between edges
    restart = 1'b1;
    for (int off = 0; off <= 6; off++) begin
      tick();
      restart = 1'b0;
    end
    check("in_stable", outv(), E_WAIT);
    #2 reset_n = 1'b0;
    #1 check("async_reset_stable", outv(), E_RST);
    @(negedge clock);
    reset_n = 1'b1;
    bringup_walk("after_stable_reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
